// File: rtl/writeback_queue.sv
// ---------------------------------------------------------------------------
// writeback_queue
//   In-order writeback stage. Instructions leaving MEM are queued in program
//   order. ALU/CSR results are ready at once. Loads wait for their memory
//   response, which arrives in load issue order. The response is extracted
//   and extended, then merged into the entry. One register-file write
//   retires per cycle from the head of the queue.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   in_valid        MEM presents an instruction (0 = bubble)
//   in_ready        queue can accept this cycle (= not full)
//   in_rd_valid     instruction writes rd
//   in_rd_addr      destination register
//   in_rd_value     ALU/CSR result (ignored for loads)
//   in_instr_id     instruction id: 1=LB 2=LH 3=LW 4=LBU 5=LHU,
//                   anything else is a non-load
//   in_addr_lo      load effective address [1:0]
//   mem_rsp_valid   load data returning, in load issue order
//   mem_rsp_data    raw aligned word from memory
//   rd_addr_out     regfile write address (registered)
//   rd_value_out    regfile write data (registered, also forwarding source)
//   wr_en_out       regfile write enable (registered)
//   pending_mask    bit r set = a queued entry will write xr
//   empty           queue holds no entries
//   err_rsp         sticky: a memory response arrived with no load waiting
// ---------------------------------------------------------------------------
module writeback_queue #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 4,
    parameter int LOAD_ALIGN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_rd_valid,
    input  logic [4:0]      in_rd_addr,
    input  logic [XLEN-1:0] in_rd_value,
    input  logic [5:0]      in_instr_id,
    input  logic [1:0]      in_addr_lo,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic [4:0]      rd_addr_out,
    output logic [XLEN-1:0] rd_value_out,
    output logic            wr_en_out,
    output logic [31:0]     pending_mask,
    output logic            empty,
    output logic            err_rsp
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [5:0] INSTR_LB  = 6'd1;
    localparam logic [5:0] INSTR_LH  = 6'd2;
    localparam logic [5:0] INSTR_LW  = 6'd3;
    localparam logic [5:0] INSTR_LBU = 6'd4;
    localparam logic [5:0] INSTR_LHU = 6'd5;

    // Queue storage
    logic            r_vld [DEPTH];
    logic            r_ok  [DEPTH];   // value is final, entry may retire
    logic            r_ld  [DEPTH];
    logic [4:0]      r_rd  [DEPTH];
    logic [XLEN-1:0] r_val [DEPTH];
    logic [5:0]      r_id  [DEPTH];
    logic [1:0]      r_alo [DEPTH];

    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [PW:0]     r_count;

    logic            r_wr_en;
    logic [4:0]      r_rd_addr;
    logic [XLEN-1:0] r_rd_value;
    logic            r_err;

    logic            w_full;
    logic            w_is_load;
    logic            w_accept;
    logic            w_enq;
    logic [4:0]      w_enq_rd;
    logic            w_retire;
    logic            w_rsp_hit;
    logic [PW-1:0]   w_rsp_ptr;
    logic            w_rsp_match;
    logic [XLEN-1:0] w_rsp_ext;

    // Byte/half extraction with sign or zero extension.
    function automatic logic [XLEN-1:0] extract(input logic [5:0] id,
                                                input logic [1:0] alo,
                                                input logic [XLEN-1:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{alo, 3'b000} +: 8];
        h = d[{alo[1], 4'b0000} +: 16];
        if (LOAD_ALIGN == 0) begin
            extract = d;
        end else begin
            case (id)
                INSTR_LB:  extract = {{(XLEN-8){b[7]}}, b};
                INSTR_LBU: extract = {{(XLEN-8){1'b0}}, b};
                INSTR_LH:  extract = {{(XLEN-16){h[15]}}, h};
                INSTR_LHU: extract = {{(XLEN-16){1'b0}}, h};
                default:   extract = d;
            endcase
        end
    endfunction

    assign w_full    = (r_count == (PW+1)'(DEPTH));
    assign in_ready  = !w_full;
    assign empty     = (r_count == '0);
    assign w_is_load = (in_instr_id == INSTR_LB)  || (in_instr_id == INSTR_LH) ||
                       (in_instr_id == INSTR_LW)  || (in_instr_id == INSTR_LBU) ||
                       (in_instr_id == INSTR_LHU);
    assign w_accept  = in_valid && in_ready;
    // Loads always occupy a slot so they consume their response, even to x0.
    assign w_enq     = w_accept && (w_is_load || (in_rd_valid && in_rd_addr != 5'd0));
    assign w_enq_rd  = in_rd_valid ? in_rd_addr : 5'd0;
    assign w_retire  = r_vld[r_head] && r_ok[r_head];

    // Response pointer: oldest queued load still waiting for data, found by
    // scanning from the head. Entries enqueued this cycle are not yet
    // visible, so a same-cycle response can never match them.
    always_comb begin
        w_rsp_hit = 1'b0;
        w_rsp_ptr = '0;
        for (int k = 0; k < DEPTH; k++) begin
            logic [PW-1:0] pos;
            pos = r_head + PW'(k);
            if (!w_rsp_hit && r_vld[pos] && r_ld[pos] && !r_ok[pos]) begin
                w_rsp_hit = 1'b1;
                w_rsp_ptr = pos;
            end
        end
    end

    assign w_rsp_match = mem_rsp_valid && w_rsp_hit;
    assign w_rsp_ext   = extract(r_id[w_rsp_ptr], r_alo[w_rsp_ptr], mem_rsp_data);

    // Entry storage. Retire slot, enqueue slot and response slot are always
    // distinct: the head only retires when ready, the tail is free, and the
    // response target is an occupied, not-yet-ready load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_vld[i] <= 1'b0;
                r_ok[i]  <= 1'b0;
                r_ld[i]  <= 1'b0;
                r_rd[i]  <= 5'd0;
                r_val[i] <= '0;
                r_id[i]  <= 6'd0;
                r_alo[i] <= 2'd0;
            end
        end else begin
            if (w_retire) begin
                r_vld[r_head] <= 1'b0;
            end
            if (w_enq) begin
                r_vld[r_tail] <= 1'b1;
                r_ok[r_tail]  <= !w_is_load;
                r_ld[r_tail]  <= w_is_load;
                r_rd[r_tail]  <= w_enq_rd;
                r_val[r_tail] <= in_rd_value;
                r_id[r_tail]  <= in_instr_id;
                r_alo[r_tail] <= in_addr_lo;
            end
            if (w_rsp_match) begin
                r_ok[w_rsp_ptr]  <= 1'b1;
                r_val[w_rsp_ptr] <= w_rsp_ext;
            end
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_retire) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_enq, w_retire})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Register-file write port and sticky response error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en    <= 1'b0;
            r_rd_addr  <= 5'd0;
            r_rd_value <= '0;
            r_err      <= 1'b0;
        end else begin
            r_wr_en <= w_retire && (r_rd[r_head] != 5'd0);
            if (w_retire) begin
                r_rd_addr  <= r_rd[r_head];
                r_rd_value <= r_val[r_head];
            end
            if (mem_rsp_valid && !w_rsp_hit) begin
                r_err <= 1'b1;
            end
        end
    end

    assign wr_en_out    = r_wr_en;
    assign rd_addr_out  = r_rd_addr;
    assign rd_value_out = r_rd_value;
    assign err_rsp      = r_err;

    // Pending-write mask: one-hot per occupied entry, ORed together. x0 never
    // contributes, so bit 0 stays clear.
    logic [DEPTH-1:0][31:0] w_entry_mask;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mask
        assign w_entry_mask[gi] = (r_vld[gi] && r_rd[gi] != 5'd0) ?
                                  (32'd1 << r_rd[gi]) : 32'd0;
    end

    always_comb begin
        pending_mask = 32'd0;
        for (int e = 0; e < DEPTH; e++) begin
            pending_mask = pending_mask | w_entry_mask[e];
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// ---------------------------------------------------------------------------
// tb_writeback_queue
//   Table of single-instruction vectors plus hand-written multi-cycle
//   sequences. Expected register writes are pushed to a scoreboard when the
//   instruction is driven; a monitor pops and compares each write.
// ---------------------------------------------------------------------------
module tb_writeback_queue;

    localparam int XLEN = 32;

    localparam logic [5:0] ID_ALU = 6'd0;
    localparam logic [5:0] ID_LB  = 6'd1;
    localparam logic [5:0] ID_LH  = 6'd2;
    localparam logic [5:0] ID_LW  = 6'd3;
    localparam logic [5:0] ID_LBU = 6'd4;
    localparam logic [5:0] ID_LHU = 6'd5;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic            in_rd_valid;
    logic [4:0]      in_rd_addr;
    logic [XLEN-1:0] in_rd_value;
    logic [5:0]      in_instr_id;
    logic [1:0]      in_addr_lo;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_data;
    logic [4:0]      rd_addr_out;
    logic [XLEN-1:0] rd_value_out;
    logic            wr_en_out;
    logic [31:0]     pending_mask;
    logic            empty;
    logic            err_rsp;

    always #5 clk = ~clk;

    writeback_queue #(.XLEN(XLEN), .DEPTH(4), .LOAD_ALIGN(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd_valid   (in_rd_valid),
        .in_rd_addr    (in_rd_addr),
        .in_rd_value   (in_rd_value),
        .in_instr_id   (in_instr_id),
        .in_addr_lo    (in_addr_lo),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .rd_addr_out   (rd_addr_out),
        .rd_value_out  (rd_value_out),
        .wr_en_out     (wr_en_out),
        .pending_mask  (pending_mask),
        .empty         (empty),
        .err_rsp       (err_rsp)
    );

    typedef struct {
        logic [5:0]  id;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [1:0]  alo;
        logic [31:0] rsp;
        int          dly;   // idle cycles before the response; 0 = non-load
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
    } wr_t;

    vec_t vecs [10];
    wr_t  sb [$];
    wr_t  mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] id, input logic rdv, input logic [4:0] rd,
                         input logic [31:0] val, input logic [1:0] alo);
        in_valid    = 1'b1;
        in_instr_id = id;
        in_rd_valid = rdv;
        in_rd_addr  = rd;
        in_rd_value = val;
        in_addr_lo  = alo;
        tick();
        in_valid    = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        tick();
        mem_rsp_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [4:0] rd, input logic [31:0] val);
        wr_t e;
        e.rd  = rd;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic wait_empty(input string name);
        int k;
        k = 0;
        while (!empty && k < 30) begin
            tick();
            k++;
        end
        check(name, 32'(empty), 32'd1);
    endtask

    // Scoreboard monitor: every register-file write must be the next
    // expected one, in order.
    always @(negedge clk) begin
        if (!rst && wr_en_out) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got x%0d=0x%08h required no write",
                         rd_addr_out, rd_value_out);
            end else begin
                mon_e = sb.pop_front();
                if (rd_addr_out !== mon_e.rd || rd_value_out !== mon_e.val) begin
                    n_fail++;
                    $display("FAIL write_data: got x%0d=0x%08h required x%0d=0x%08h",
                             rd_addr_out, rd_value_out, mon_e.rd, mon_e.val);
                end else begin
                    $display("[TB] write x%0d = 0x%08h", rd_addr_out, rd_value_out);
                end
            end
        end
    end

    initial begin
        vecs[0] = '{ID_ALU, 5'd5,  32'h0000_1234, 2'd0, 32'h0,         0, 32'h0000_1234};
        vecs[1] = '{ID_LB,  5'd6,  32'h0,         2'd3, 32'h80FF_FF01, 2, 32'hFFFF_FF80};
        vecs[2] = '{ID_LBU, 5'd6,  32'h0,         2'd3, 32'h80FF_FF01, 2, 32'h0000_0080};
        vecs[3] = '{ID_LH,  5'd6,  32'h0,         2'd2, 32'h80FF_FF01, 2, 32'hFFFF_80FF};
        vecs[4] = '{ID_LHU, 5'd9,  32'h0,         2'd3, 32'h80FF_FF01, 1, 32'h0000_80FF};
        vecs[5] = '{ID_LW,  5'd10, 32'h5555_5555, 2'd2, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF};
        vecs[6] = '{ID_LB,  5'd11, 32'h0,         2'd0, 32'h80FF_FF01, 3, 32'h0000_0001};
        vecs[7] = '{ID_LBU, 5'd12, 32'h0,         2'd1, 32'h1234_5678, 1, 32'h0000_0056};
        vecs[8] = '{ID_LH,  5'd13, 32'h0,         2'd1, 32'h1234_8765, 1, 32'hFFFF_8765};
        vecs[9] = '{ID_ALU, 5'd31, 32'hFFFF_FFFF, 2'd0, 32'h0,         0, 32'hFFFF_FFFF};

        rst           = 1'b1;
        in_valid      = 1'b0;
        in_rd_valid   = 1'b0;
        in_rd_addr    = 5'd0;
        in_rd_value   = '0;
        in_instr_id   = ID_ALU;
        in_addr_lo    = 2'd0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        tick();
        tick();
        check("reset_wr_en",   32'(wr_en_out),    32'd0);
        check("reset_rd_addr", 32'(rd_addr_out),  32'd0);
        check("reset_value",   rd_value_out,      32'd0);
        check("reset_empty",   32'(empty),        32'd1);
        check("reset_ready",   32'(in_ready),     32'd1);
        check("reset_mask",    pending_mask,      32'd0);
        check("reset_err",     32'(err_rsp),      32'd0);
        rst = 1'b0;
        tick();

        // Table: one instruction into an empty queue each
        for (int i = 0; i < 10; i++) begin
            push_exp(vecs[i].rd, vecs[i].exp);
            issue(vecs[i].id, 1'b1, vecs[i].rd, vecs[i].val, vecs[i].alo);
            check("mask_set", 32'(pending_mask[vecs[i].rd]), 32'd1);
            if (vecs[i].dly > 0) begin
                for (int d = 0; d < vecs[i].dly; d++) begin
                    check("load_no_early_write", 32'(wr_en_out), 32'd0);
                    tick();
                end
                respond(vecs[i].rsp);
                check("load_wait_after_rsp", 32'(wr_en_out), 32'd0);
            end
            tick();
            check("write_latency", 32'(wr_en_out), 32'd1);
            check("mask_clear", pending_mask, 32'd0);
            tick();
            check("idle_wr_en", 32'(wr_en_out), 32'd0);
            check("idle_hold_value", rd_value_out, vecs[i].exp);
        end

        // Older load blocks a younger ready ALU entry
        push_exp(5'd7, 32'hCAFE_F00D);
        push_exp(5'd8, 32'd9);
        issue(ID_LW, 1'b1, 5'd7, 32'h0, 2'd0);
        issue(ID_ALU, 1'b1, 5'd8, 32'd9, 2'd0);
        check("order_mask", pending_mask, 32'h0000_0180);
        for (int d = 0; d < 4; d++) begin
            check("order_blocked", 32'(wr_en_out), 32'd0);
            tick();
        end
        respond(32'hCAFE_F00D);
        tick();
        check("order_first_en", 32'(wr_en_out), 32'd1);
        check("order_first_rd", 32'(rd_addr_out), 32'd7);
        tick();
        check("order_second_en", 32'(wr_en_out), 32'd1);
        check("order_second_rd", 32'(rd_addr_out), 32'd8);
        tick();

        // Fill with loads, no responses: full back-pressure
        for (int k = 1; k <= 4; k++) begin
            push_exp(5'(k), 32'h1111_1111 * k);
            issue(ID_LW, 1'b1, 5'(k), 32'h0, 2'd0);
        end
        check("full_ready", 32'(in_ready), 32'd0);
        check("full_empty", 32'(empty), 32'd0);
        check("full_mask", pending_mask, 32'h0000_001E);
        in_valid    = 1'b1;
        in_instr_id = ID_ALU;
        in_rd_valid = 1'b1;
        in_rd_addr  = 5'd20;
        in_rd_value = 32'h2020_2020;
        tick();
        tick();
        check("full_not_accepted", 32'(pending_mask[20]), 32'd0);
        check("full_ready_held", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            respond(32'h1111_1111 * k);
        end
        wait_empty("full_drain_empty");
        tick();
        check("full_drain_mask", pending_mask, 32'd0);

        // Spurious response and dropped writes
        check("err_clear_before", 32'(err_rsp), 32'd0);
        respond(32'h5555_AAAA);
        check("err_set", 32'(err_rsp), 32'd1);
        check("err_no_write", 32'(wr_en_out), 32'd0);
        tick();
        tick();
        check("err_sticky", 32'(err_rsp), 32'd1);
        issue(ID_ALU, 1'b1, 5'd0, 32'h77, 2'd0);
        check("x0_no_enqueue", 32'(empty), 32'd1);
        issue(ID_ALU, 1'b0, 5'd3, 32'h33, 2'd0);
        check("norv_no_enqueue", 32'(empty), 32'd1);
        tick();
        check("x0_no_write", 32'(wr_en_out), 32'd0);

        // Asynchronous reset with entries queued and a load outstanding
        issue(ID_LW,  1'b1, 5'd14, 32'h0,  2'd0);
        issue(ID_ALU, 1'b1, 5'd15, 32'h15, 2'd0);
        issue(ID_ALU, 1'b1, 5'd16, 32'h16, 2'd0);
        check("pre_reset_mask", pending_mask, 32'h0001_C000);
        #2;
        rst = 1'b1;
        #1;
        check("arst_wr_en",   32'(wr_en_out),   32'd0);
        check("arst_rd_addr", 32'(rd_addr_out), 32'd0);
        check("arst_value",   rd_value_out,     32'd0);
        check("arst_empty",   32'(empty),       32'd1);
        check("arst_mask",    pending_mask,     32'd0);
        check("arst_err",     32'(err_rsp),     32'd0);
        tick();
        rst = 1'b0;
        tick();
        respond(32'h9999_9999);
        check("late_rsp_err", 32'(err_rsp), 32'd1);
        check("late_rsp_empty", 32'(empty), 32'd1);
        tick();
        check("late_rsp_no_write", 32'(wr_en_out), 32'd0);
        tick();

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
